// File: rtl/trap_csr_monitor_pkg.sv
// Shared definitions for the trap/CSR monitor: mstatus field positions, privilege
// codes, FSM/event encodings, rule indices and the error-log entry layout.
package trap_mon_pkg;

  localparam int unsigned MS_SIE    = 1;
  localparam int unsigned MS_MIE    = 3;
  localparam int unsigned MS_SPIE   = 5;
  localparam int unsigned MS_MPIE   = 7;
  localparam int unsigned MS_SPP    = 8;
  localparam int unsigned MS_MPP_LO = 11;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_HALTED   = 2'd2
  } mon_state_e;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_TRAP = 2'd1,
    EV_MRET = 2'd2,
    EV_SRET = 2'd3
  } ev_type_e;

  localparam int unsigned R_MIE_CLR = 0;
  localparam int unsigned R_MPIE    = 1;
  localparam int unsigned R_MPP     = 2;
  localparam int unsigned R_S_PRIV  = 3;
  localparam int unsigned R_M_PRIV  = 4;
  localparam int unsigned R_MRET    = 5;
  localparam int unsigned R_SRET    = 6;
  localparam int unsigned R_CAUSE   = 7;

  typedef struct packed {
    logic [7:0]  mask;
    logic [1:0]  priv;
    ev_type_e    ev;
    logic [3:0]  cause;
    logic [15:0] ts;
  } log_entry_t;

  localparam logic [3:0] CAUSE_ORDER [14] = '{4'd3, 4'd12, 4'd1, 4'd2, 4'd0, 4'd8, 4'd9,
                                               4'd11, 4'd4, 4'd6, 4'd5, 4'd7, 4'd13, 4'd15};

  // Returns {found, cause}; scanning from lowest priority up lets the highest one win.
  function automatic logic [4:0] first_cause(input logic [15:0] vec);
    logic [4:0] r;
    r = '0;
    for (int unsigned i = 14; i > 0; i--) begin
      if (vec[CAUSE_ORDER[i-1]]) r = {1'b1, CAUSE_ORDER[i-1]};
    end
    return r;
  endfunction

endpackage

// File: rtl/trap_csr_monitor_if.sv
// CSR and trap-event bus observed by the monitor.
interface trap_csr_monitor_if #(parameter int XLEN = 64);
  logic [XLEN-1:0] mstatus, mcause, scause, mideleg, medeleg, causeNO;
  logic [15:0]     raiseExceptionVec;
  logic [1:0]      priviledgeMode;
  logic            raiseTrap, raiseIntr, mRet, sRet, instValid;

  modport master (output mstatus, mcause, scause, mideleg, medeleg, causeNO,
                  raiseExceptionVec, priviledgeMode, raiseTrap, raiseIntr, mRet, sRet, instValid);
  modport slave  (input  mstatus, mcause, scause, mideleg, medeleg, causeNO,
                  raiseExceptionVec, priviledgeMode, raiseTrap, raiseIntr, mRet, sRet, instValid);
endinterface

// File: rtl/trap_mon_log_fifo.sv
// Error-log FIFO: drops pushes when full (sticky overflow) unless a pop frees a slot.
module trap_mon_log_fifo #(
  parameter int WIDTH     = 32,
  parameter int LOG_DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             overflow
);
  localparam int unsigned DEPTH = 1 << LOG_DEPTH;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [LOG_DEPTH:0]   count;
  logic                 full, pop, wr;

  assign valid = (count != '0);
  assign full  = count[LOG_DEPTH];
  assign pop   = valid && ready;
  assign wr    = push && (!full || pop);
  assign data  = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + LOG_DEPTH'(1);
      if (pop) rd_ptr <= rd_ptr + LOG_DEPTH'(1);
      if (wr && !pop)      count <= count + (LOG_DEPTH+1)'(1);
      else if (pop && !wr) count <= count - (LOG_DEPTH+1)'(1);
      if (push && !wr) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/trap_csr_monitor.sv
// Two-stage trap/return checker: stage 1 snapshots pre-event CSR state, stage 2
// checks the post-event state, accumulates sticky errors and logs violations.
module trap_csr_monitor
  import trap_mon_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int LOG_DEPTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     halt_on_err,
  input  logic                     clear,
  input  logic [7:0]               rule_en,
  trap_csr_monitor_if.slave        csr,
  input  logic                     log_ready,
  output logic [7:0]               err_sticky,
  output logic                     err_any,
  output logic [15:0]              viol_cnt,
  output logic                     log_valid,
  output logic [31:0]              log_data,
  output logic                     log_overflow,
  output logic [1:0]               state
);
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("trap_csr_monitor: XLEN must be 32 or 64");
  end

  mon_state_e      cur_st, nxt_st;
  ev_type_e        ev_in, s1_ev;
  logic [15:0]     ts;
  logic [XLEN-1:0] deleg, sel_cause;
  logic [4:0]      cause_in;
  logic            mtrap_in, capture, viol;
  logic [7:0]      viol_raw, viol_mask;
  log_entry_t      entry;
  logic            s1_vld, s1_mie, s1_mpie, s1_spie, s1_spp, s1_mtrap, s1_intr, s1_cause_vld;
  logic [1:0]      s1_priv, s1_mpp;
  logic [3:0]      s1_cause;
  logic            unused_bits;

  assign unused_bits = ^{csr.causeNO, csr.mstatus};

  always_comb begin
    ev_in = EV_NONE;
    if (csr.raiseTrap)                     ev_in = EV_TRAP;
    else if (csr.mRet && csr.instValid)    ev_in = EV_MRET;
    else if (csr.sRet && csr.instValid)    ev_in = EV_SRET;
  end

  assign deleg    = csr.raiseIntr ? csr.mideleg : csr.medeleg;
  assign mtrap_in = !(deleg[csr.causeNO[3:0]] && (csr.priviledgeMode != PRIV_M));
  assign cause_in = first_cause(csr.raiseExceptionVec);

  always_comb begin
    nxt_st = cur_st;
    unique case (cur_st)
      ST_DISABLED: if (enable) nxt_st = ST_ARMED;
      ST_ARMED: begin
        if (!enable)                           nxt_st = ST_DISABLED;
        else if (viol && halt_on_err && !clear) nxt_st = ST_HALTED;
      end
      ST_HALTED:   if (clear) nxt_st = enable ? ST_ARMED : ST_DISABLED;
      default:     nxt_st = ST_DISABLED;
    endcase
  end

  // The event seen in the halting cycle is not captured, so nothing is checked after the halt.
  assign capture = (cur_st == ST_ARMED) && (nxt_st != ST_HALTED) && (ev_in != EV_NONE);

  assign sel_cause = s1_mtrap ? csr.mcause : csr.scause;

  always_comb begin
    viol_raw = '0;
    if (s1_ev == EV_TRAP) begin
      if (s1_mtrap) begin
        viol_raw[R_MIE_CLR] = csr.mstatus[MS_MIE];
        viol_raw[R_MPIE]    = csr.mstatus[MS_MPIE] != s1_mie;
        viol_raw[R_MPP]     = csr.mstatus[MS_MPP_LO +: 2] != s1_priv;
        viol_raw[R_M_PRIV]  = csr.priviledgeMode != PRIV_M;
      end else begin
        viol_raw[R_S_PRIV]  = csr.priviledgeMode != PRIV_S;
      end
      viol_raw[R_CAUSE] = !s1_intr && s1_cause_vld &&
                          (sel_cause != {{(XLEN-4){1'b0}}, s1_cause});
    end
    if (s1_ev == EV_MRET)
      viol_raw[R_MRET] = (csr.priviledgeMode != s1_mpp) || (csr.mstatus[MS_MIE] != s1_mpie);
    if (s1_ev == EV_SRET)
      viol_raw[R_SRET] = (csr.priviledgeMode != {1'b0, s1_spp}) || (csr.mstatus[MS_SIE] != s1_spie);
  end

  assign viol_mask = s1_vld ? (viol_raw & rule_en) : '0;
  assign viol      = |viol_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_st     <= ST_DISABLED;
      ts         <= '0;
      s1_vld     <= 1'b0;
      err_sticky <= '0;
      viol_cnt   <= '0;
    end else begin
      cur_st <= nxt_st;
      ts     <= ts + 16'd1;
      s1_vld <= capture;
      if (clear) begin
        err_sticky <= '0;
        viol_cnt   <= '0;
      end else if (viol) begin
        err_sticky <= err_sticky | viol_mask;
        if (viol_cnt != '1) viol_cnt <= viol_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      s1_ev        <= ev_in;
      s1_priv      <= csr.priviledgeMode;
      s1_mie       <= csr.mstatus[MS_MIE];
      s1_mpie      <= csr.mstatus[MS_MPIE];
      s1_spie      <= csr.mstatus[MS_SPIE];
      s1_spp       <= csr.mstatus[MS_SPP];
      s1_mpp       <= csr.mstatus[MS_MPP_LO +: 2];
      s1_mtrap     <= mtrap_in;
      s1_intr      <= csr.raiseIntr;
      s1_cause_vld <= cause_in[4];
      s1_cause     <= cause_in[3:0];
    end
  end

  always_comb begin
    entry.mask  = viol_mask;
    entry.priv  = s1_priv;
    entry.ev    = s1_ev;
    entry.cause = s1_cause_vld ? s1_cause : 4'd0;
    entry.ts    = ts;
  end

  trap_mon_log_fifo #(.WIDTH(32), .LOG_DEPTH(LOG_DEPTH)) u_log (
    .clk       (clk),
    .reset     (reset),
    .flush     (clear),
    .push      (viol && !clear),
    .push_data (entry),
    .ready     (log_ready),
    .valid     (log_valid),
    .data      (log_data),
    .overflow  (log_overflow)
  );

  assign err_any = |err_sticky;
  assign state   = cur_st;
endmodule

// File: tb/tb_trap_csr_monitor.sv
// Directed bench for trap_csr_monitor: table of trap/return vectors plus
// hand-written sequences for reset, halt, clear, overflow and saturation.
module tb_trap_csr_monitor;
  import trap_mon_pkg::*;

  localparam int XLEN = 64;

  logic        clk = 1'b0;
  logic        reset, enable, halt_on_err, clear, log_ready;
  logic [7:0]  rule_en;
  logic [7:0]  err_sticky;
  logic        err_any, log_valid, log_overflow;
  logic [15:0] viol_cnt;
  logic [31:0] log_data;
  logic [1:0]  state;
  logic [15:0] ts_model;

  always #5 clk = ~clk;

  always @(posedge clk) ts_model <= reset ? 16'd0 : ts_model + 16'd1;

  trap_csr_monitor_if #(.XLEN(XLEN)) csr ();

  trap_csr_monitor #(.XLEN(XLEN), .LOG_DEPTH(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .halt_on_err  (halt_on_err),
    .clear        (clear),
    .rule_en      (rule_en),
    .csr          (csr),
    .log_ready    (log_ready),
    .err_sticky   (err_sticky),
    .err_any      (err_any),
    .viol_cnt     (viol_cnt),
    .log_valid    (log_valid),
    .log_data     (log_data),
    .log_overflow (log_overflow),
    .state        (state)
  );

  typedef struct {
    logic        trap, intr, mret, sret, ivalid;
    logic [1:0]  priv;
    logic [63:0] pre_ms, medeleg, mideleg, cause_no;
    logic [15:0] exc;
    logic [1:0]  post_priv;
    logic [63:0] post_ms, mcause, scause;
    logic [7:0]  ren, exp_mask;
    logic [15:0] exp_hi;
  } vec_t;

  vec_t vecs[16];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ms(input int mpp, input int spp, input int mpie,
                                     input int spie, input int mie, input int sie);
    logic [63:0] m;
    m = '0;
    m[12:11] = 2'(mpp);
    m[8] = 1'(spp);
    m[7] = 1'(mpie);
    m[5] = 1'(spie);
    m[3] = 1'(mie);
    m[1] = 1'(sie);
    return m;
  endfunction

  task automatic idle();
    csr.raiseTrap = 0; csr.raiseIntr = 0; csr.mRet = 0; csr.sRet = 0; csr.instValid = 0;
  endtask

  task automatic apply_pre(input vec_t v);
    csr.raiseTrap = v.trap; csr.raiseIntr = v.intr; csr.mRet = v.mret; csr.sRet = v.sret;
    csr.instValid = v.ivalid; csr.priviledgeMode = v.priv; csr.mstatus = v.pre_ms;
    csr.medeleg = v.medeleg; csr.mideleg = v.mideleg; csr.causeNO = v.cause_no;
    csr.raiseExceptionVec = v.exc; rule_en = v.ren;
  endtask

  task automatic apply_post(input vec_t v);
    idle();
    csr.priviledgeMode = v.post_priv; csr.mstatus = v.post_ms;
    csr.mcause = v.mcause; csr.scause = v.scause;
  endtask

  task automatic run_vec(input vec_t v);
    apply_pre(v);
    step();
    apply_post(v);
    step();
  endtask

  initial begin
    int n;
    logic [15:0] exp_ts;

    //        trap intr mret sret iv priv pre_ms            medeleg  mideleg cno  exc       ppriv post_ms          mcause scause ren    mask   hi
    vecs[0]  = '{1, 0, 0, 0, 1, 2'd0, ms(0,0,0,0,1,0), 64'h0,    64'h0, 64'd2,  16'h0004, 2'd3, ms(0,0,1,0,0,0), 64'd2,   64'd0, 8'hFF, 8'h00, 16'h0000};
    vecs[1]  = '{1, 0, 0, 0, 1, 2'd0, ms(0,0,0,0,1,0), 64'h0,    64'h0, 64'd2,  16'h0004, 2'd3, ms(1,0,1,0,0,0), 64'd2,   64'd0, 8'hFF, 8'h04, 16'h0412};
    vecs[2]  = '{1, 0, 0, 0, 1, 2'd3, ms(0,0,0,0,0,0), 64'h0,    64'h0, 64'd12, 16'h1002, 2'd3, ms(3,0,0,0,0,0), 64'd1,   64'd0, 8'hFF, 8'h80, 16'h80DC};
    vecs[3]  = '{1, 0, 0, 0, 1, 2'd3, ms(0,0,0,0,0,0), 64'h0,    64'h0, 64'd12, 16'h1002, 2'd3, ms(3,0,0,0,0,0), 64'd1,   64'd0, 8'h7F, 8'h00, 16'h0000};
    vecs[4]  = '{1, 0, 0, 0, 1, 2'd0, ms(0,0,0,0,1,1), 64'h4,    64'h0, 64'd2,  16'h0004, 2'd1, ms(0,0,0,0,1,1), 64'd0,   64'd2, 8'hFF, 8'h00, 16'h0000};
    vecs[5]  = '{1, 0, 0, 0, 1, 2'd0, ms(0,0,0,0,1,1), 64'h4,    64'h0, 64'd2,  16'h0004, 2'd3, ms(0,0,0,0,1,1), 64'd0,   64'd5, 8'hFF, 8'h88, 16'h8812};
    vecs[6]  = '{1, 0, 0, 0, 1, 2'd3, ms(0,0,0,0,1,0), 64'h4,    64'h0, 64'd2,  16'h0004, 2'd3, ms(3,0,1,0,1,0), 64'd2,   64'd0, 8'hFF, 8'h01, 16'h01D2};
    vecs[7]  = '{1, 1, 0, 0, 0, 2'd1, ms(0,0,0,0,1,0), 64'hFFFF, 64'h0, 64'd7,  16'h0000, 2'd3, ms(1,0,1,0,0,0), 64'd999, 64'd0, 8'hFF, 8'h00, 16'h0000};
    vecs[8]  = '{0, 0, 1, 0, 1, 2'd3, ms(1,0,1,0,0,0), 64'h0,    64'h0, 64'd0,  16'h0000, 2'd1, ms(0,0,0,0,1,0), 64'd0,   64'd0, 8'hFF, 8'h00, 16'h0000};
    vecs[9]  = '{0, 0, 1, 0, 1, 2'd3, ms(1,0,1,0,0,0), 64'h0,    64'h0, 64'd0,  16'h0000, 2'd0, ms(0,0,0,0,0,0), 64'd0,   64'd0, 8'hFF, 8'h20, 16'h20E0};
    vecs[10] = '{0, 0, 0, 1, 1, 2'd1, ms(0,0,0,1,0,0), 64'h0,    64'h0, 64'd0,  16'h0000, 2'd0, ms(0,0,0,0,0,1), 64'd0,   64'd0, 8'hFF, 8'h00, 16'h0000};
    vecs[11] = '{0, 0, 0, 1, 1, 2'd1, ms(0,0,0,1,0,0), 64'h0,    64'h0, 64'd0,  16'h0000, 2'd1, ms(0,0,0,0,0,1), 64'd0,   64'd0, 8'hFF, 8'h40, 16'h4070};
    vecs[12] = '{0, 0, 1, 0, 0, 2'd3, ms(3,0,1,0,0,0), 64'h0,    64'h0, 64'd0,  16'h0000, 2'd0, ms(0,0,0,0,0,0), 64'd0,   64'd0, 8'hFF, 8'h00, 16'h0000};
    vecs[13] = '{1, 0, 1, 0, 1, 2'd0, ms(0,0,0,0,1,0), 64'h0,    64'h0, 64'd2,  16'h0004, 2'd3, ms(0,0,1,0,0,0), 64'd2,   64'd0, 8'hFF, 8'h00, 16'h0000};
    vecs[14] = '{1, 0, 0, 0, 1, 2'd3, ms(0,0,0,0,0,0), 64'h0,    64'h0, 64'd0,  16'h0111, 2'd3, ms(3,0,0,0,0,0), 64'd0,   64'd0, 8'hFF, 8'h00, 16'h0000};
    vecs[15] = '{1, 0, 0, 0, 1, 2'd3, ms(0,0,0,0,0,0), 64'h0,    64'h0, 64'd0,  16'hA000, 2'd3, ms(3,0,0,0,0,0), 64'd15,  64'd0, 8'hFF, 8'h80, 16'h80DD};

    reset = 1; enable = 0; halt_on_err = 0; clear = 0; log_ready = 0; rule_en = 8'hFF;
    idle();
    csr.mstatus = '0; csr.mcause = '0; csr.scause = '0; csr.mideleg = '0; csr.medeleg = '0;
    csr.causeNO = '0; csr.raiseExceptionVec = '0; csr.priviledgeMode = 2'd0;
    step(); step();
    reset = 0;
    check("rst_state", 32'(state), 32'd0);
    check("rst_sticky", 32'(err_sticky), 32'd0);
    check("rst_any", 32'(err_any), 32'd0);
    check("rst_cnt", 32'(viol_cnt), 32'd0);
    check("rst_lvalid", 32'(log_valid), 32'd0);
    check("rst_ldata", log_data, 32'd0);
    check("rst_ovf", 32'(log_overflow), 32'd0);

    run_vec(vecs[1]);
    check("disabled_cnt", 32'(viol_cnt), 32'd0);
    check("disabled_state", 32'(state), 32'd0);

    enable = 1;
    step();
    check("armed_state", 32'(state), 32'd1);

    for (int i = 0; i < 16; i++) begin
      clear = 1; idle(); step(); clear = 0;
      run_vec(vecs[i]);
      check($sformatf("v%0d_sticky", i), 32'(err_sticky), 32'(vecs[i].exp_mask));
      check($sformatf("v%0d_any", i), 32'(err_any), 32'(vecs[i].exp_mask != 0));
      check($sformatf("v%0d_cnt", i), 32'(viol_cnt), 32'(vecs[i].exp_mask != 0));
      check($sformatf("v%0d_lvalid", i), 32'(log_valid), 32'(vecs[i].exp_mask != 0));
      if (vecs[i].exp_mask != 0) begin
        exp_ts = ts_model - 16'd1;
        check($sformatf("v%0d_lhi", i), 32'(log_data[31:16]), 32'(vecs[i].exp_hi));
        check($sformatf("v%0d_lts", i), 32'(log_data[15:0]), 32'(exp_ts));
      end
    end
    rule_en = 8'hFF;

    // clear wins over a violation checked in the same cycle
    clear = 1; idle(); step(); clear = 0;
    apply_pre(vecs[1]); step(); apply_post(vecs[1]); clear = 1; step(); clear = 0;
    check("clrpri_sticky", 32'(err_sticky), 32'd0);
    check("clrpri_cnt", 32'(viol_cnt), 32'd0);
    check("clrpri_lvalid", 32'(log_valid), 32'd0);

    // halt on first violation, ignore later ones, recover with clear
    halt_on_err = 1;
    run_vec(vecs[1]);
    check("halt_state", 32'(state), 32'd2);
    check("halt_cnt", 32'(viol_cnt), 32'd1);
    run_vec(vecs[9]);
    check("halted_cnt", 32'(viol_cnt), 32'd1);
    check("halted_sticky", 32'(err_sticky), 32'h04);
    check("halted_state", 32'(state), 32'd2);
    clear = 1; step(); clear = 0; halt_on_err = 0;
    check("unhalt_state", 32'(state), 32'd1);
    check("unhalt_cnt", 32'(viol_cnt), 32'd0);
    check("unhalt_lvalid", 32'(log_valid), 32'd0);

    // reset between capture and check discards the snapshot
    apply_pre(vecs[1]); step(); apply_post(vecs[1]); reset = 1; step(); reset = 0;
    check("midrst_state", 32'(state), 32'd0);
    step();
    check("midrst_cnt", 32'(viol_cnt), 32'd0);
    check("midrst_lvalid", 32'(log_valid), 32'd0);
    check("midrst_rearm", 32'(state), 32'd1);

    // 9 back-to-back cause violations into an 8-deep log
    rule_en = 8'h80;
    csr.raiseTrap = 1; csr.instValid = 1; csr.raiseIntr = 0; csr.priviledgeMode = 2'd3;
    csr.medeleg = '0; csr.raiseExceptionVec = 16'h0008; csr.mcause = '0;
    for (int i = 0; i < 9; i++) step();
    idle(); step();
    check("ovf_cnt", 32'(viol_cnt), 32'd9);
    check("ovf_flag", 32'(log_overflow), 32'd1);
    check("ovf_sticky", 32'(err_sticky), 32'h80);
    check("ovf_lvalid", 32'(log_valid), 32'd1);
    check("ovf_head_mask", 32'(log_data[31:24]), 32'h80);
    log_ready = 1;
    n = 0;
    while (log_valid && n < 20) begin
      step();
      n++;
    end
    log_ready = 0;
    check("ovf_pops", 32'(n), 32'd8);
    check("ovf_drained", 32'(log_valid), 32'd0);

    // counter saturation
    clear = 1; step(); clear = 0;
    csr.raiseTrap = 1; csr.instValid = 1;
    for (int i = 0; i < 65540; i++) step();
    idle(); step();
    check("sat_cnt", 32'(viol_cnt), 32'hFFFF);

    enable = 0; step();
    check("disable_state", 32'(state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
